// File: rtl/cdb_pkg.sv
// Shared constants, unit indices and the CDB broadcast record for the
// common-data-bus scheduler and everything that listens to it.
package cdb_pkg;

  localparam int CDB_NUM_REQ   = 5;
  localparam int CDB_PAYLOAD_W = 40;
  localparam int CDB_IDX_W     = 3;

  // Requester slots on the CDB, in their fixed-priority order.
  localparam logic [CDB_IDX_W-1:0] CDB_ALU = 3'd0;
  localparam logic [CDB_IDX_W-1:0] CDB_MUL = 3'd1;
  localparam logic [CDB_IDX_W-1:0] CDB_DIV = 3'd2;
  localparam logic [CDB_IDX_W-1:0] CDB_LS  = 3'd3;
  localparam logic [CDB_IDX_W-1:0] CDB_BR  = 3'd4;

  typedef struct packed {
    logic                     valid;
    logic [CDB_PAYLOAD_W-1:0] payload;
  } cdb_t;

  // Successor of idx in a ring of n slots.
  function automatic int unsigned cdb_next_idx(input int unsigned idx,
                                               input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational rotating priority encoder: scans req upward from start,
// wrapping at NUM_REQ-1, and reports the first requester found.
module cdb_rr_pick
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int IDX_W   = CDB_IDX_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   win,
  output logic               any_grant
);

  logic [IDX_W-1:0] base;

  // An out-of-range start can only come from a corrupted pointer; fall back to slot 0.
  assign base = (32'(start) < NUM_REQ) ? start : '0;

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the search loop so no path
    // through this block leaves a value unassigned, which would infer a latch.
    gnt       = '0;
    win       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, base} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        win       = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_rr_scheduler.sv
// Common data bus scheduler: round-robin grant among the functional units and
// the registered CDB broadcast. Define CDB_FIXED_PRIORITY_EN for fixed priority.
module cdb_rr_scheduler
  import cdb_pkg::*;
#(
  parameter int NUM_REQ   = CDB_NUM_REQ,
  parameter int PAYLOAD_W = CDB_PAYLOAD_W,
  parameter int IDX_W     = CDB_IDX_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   data_in,
  input  logic                           flush,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [PAYLOAD_W:0]             cdb,
  output logic [IDX_W-1:0]               cdb_src
);

  logic [IDX_W-1:0]     start_idx;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_win;
  logic                 pick_any;
  logic                 grant_now;
  logic [PAYLOAD_W-1:0] payload_sel;

  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req),
    .start     (start_idx),
    .gnt       (pick_gnt),
    .win       (pick_win),
    .any_grant (pick_any)
  );

  // Reset beats flush, flush beats any request.
  assign grant_now = pick_any && !rst && !flush;
  assign gnt       = grant_now ? pick_gnt : '0;

`ifdef CDB_FIXED_PRIORITY_EN
  assign start_idx = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement or block order.
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_now) begin
      rr_ptr <= IDX_W'(cdb_next_idx(32'(pick_win), NUM_REQ));
    end
  end

  assign start_idx = rr_ptr;
`endif

  always_comb begin
    payload_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_win == IDX_W'(i)) begin
        payload_sel = data_in[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // cdb_src keeps naming the last owner across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb     <= '0;
      cdb_src <= '0;
    end else if (grant_now) begin
      cdb     <= {1'b1, payload_sel};
      cdb_src <= pick_win;
    end else begin
      cdb     <= '0;
    end
  end

endmodule

// File: doc/cdb_rr_scheduler.md
Name: cdb_rr_scheduler

Overview:
- Round-robin scheduler for the single common data bus (CDB).
- Shares the CDB among five functional-unit requesters: ALU, mul, div, ld/st and branch.
- Returns a one-hot grant so each losing unit holds its result.
- Drives the registered CDB broadcast and the source-unit index to reservation stations, register status and ROB. Sits between the functional units and all CDB listeners.

Parameters:
- NUM_REQ, 5, number of requesters; index 0=ALU, 1=mul, 2=div, 3=ls, 4=branch.
- PAYLOAD_W, 40, per-requester payload width (tag + result).
- IDX_W, 3, width of requester index; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-unit broadcast request; bit i = unit i
- data_in  in  NUM_REQ*PAYLOAD_W  packed payloads; unit i at bits [i*PAYLOAD_W +: PAYLOAD_W]
- flush  in  1  mispredict/flush; suppresses arbitration this cycle
- gnt  out  NUM_REQ  one-hot grant, combinational, valid in the request cycle
- cdb  out  PAYLOAD_W+1  registered broadcast {valid, payload}
- cdb_src  out  IDX_W  registered index of the unit that owns the current cdb

Behaviour:
- Reset, synchronous, active-high:
  - cdb=0, cdb_src=0, rr_ptr=0.
  - gnt forced to 0 while rst=1.
  - Reset mid-arbitration discards the pending winner; nothing is broadcast on the next cycle.
- Arbitration (combinational):
  - Search req starting at index rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - First set bit wins; gnt = one-hot of the winner.
  - gnt = 0 if req==0, flush=1 or rst=1.
- Requester handshake:
  - Unit asserts req with stable data_in.
  - It must hold both until it samples gnt[i]=1 at a rising edge; the transfer completes at that edge.
  - The unit may re-assert req on the following cycle for a new result.
  - Never drop req before it is granted.
- Broadcast (registered, 1-cycle latency):
  - At the edge where gnt[w]=1: cdb <= {1'b1, payload_w}, cdb_src <= w.
  - Otherwise: cdb <= {1'b0, 0}; cdb_src holds its previous value.
  - Every cycle with any grant produces exactly one valid broadcast the next cycle; back-to-back grants give back-to-back valid cdb cycles.
- Pointer update:
  - On a grant to w: rr_ptr <= (w==NUM_REQ-1) ? 0 : w+1.
  - No grant, flush or rst: rr_ptr unchanged (rst sets it to 0).
  - Fairness bound: any continuously requesting unit is granted within NUM_REQ cycles.
- Flush:
  - A flush cycle grants nobody and produces an invalid cdb next cycle.
  - A broadcast already registered in cdb is not cancelled.
- Simultaneous events:
  - rst dominates flush.
  - flush dominates req.
  - A req arriving in the same cycle as a grant to another unit waits; there is no combinational bypass.

Optional Feature:
- Macro: CDB_FIXED_PRIORITY_EN.
- Defined:
  - rr_ptr is removed and the search always starts at index 0: ALU > mul > div > ls > branch.
  - Handshake, latency and flush behaviour are unchanged.
  - No fairness guarantee.
- Undefined: round-robin behaviour as above.

Decomposition:
- Shared package cdb_pkg:
  - Constants CDB_NUM_REQ=5, CDB_PAYLOAD_W=40, CDB_IDX_W=3.
  - Unit indices CDB_ALU=0, CDB_MUL=1, CDB_DIV=2, CDB_LS=3, CDB_BR=4.
  - cdb_t packed typedef {valid, payload}.
- One sub-module, cdb_rr_pick: combinational rotating priority encoder.
  - Inputs: req, start index.
  - Outputs: one-hot grant, winner index, any_grant.
  - Top level holds only the rr_ptr, cdb and cdb_src registers plus the data mux.

Test Plan:
- rst=1 two cycles with req=5'b11111 -> gnt=0 throughout; cdb=0 and cdb_src=0 the cycle after rst drops, before any grant registers.
- Single request: req=5'b00100, data_in[2]=40'hA5_0000_1234 -> gnt=5'b00100 that cycle; next cycle cdb={1,40'hA5_0000_1234}, cdb_src=2, rr_ptr=3.
- Sustained contention: req=5'b11111 held for 10 cycles from reset -> grant order 0,1,2,3,4,0,1,2,3,4; cdb valid every cycle from cycle 2 and rr_ptr wraps 4->0.
- Flush: req=5'b00011 with flush=1 for one cycle -> gnt=0, next cdb valid=0, rr_ptr unchanged; flush=0 next cycle -> grant to index rr_ptr-first.
- Reset mid-operation: grant to unit 3 then rst=1 on the following cycle -> broadcast from unit 3 appears, then cdb=0 and rr_ptr=0 after reset edge; req=5'b10001 afterwards grants unit 0 first.
- With CDB_FIXED_PRIORITY_EN: req=5'b11000 for 3 cycles -> unit 3 granted all 3 cycles, unit 4 starved; without the macro -> 3,4,3.
